// File: rtl/mux_channel_scanner_pkg.sv
// -----------------------------------------------------------------------------
// mux_channel_scanner_pkg
// Shared definitions for the 4-to-1 mux channel scanner.
//   state_t : FSM state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   SEL_W   : width of the mux select {s1,s0}
//   NUM_CH  : number of mux channels scanned per word
// -----------------------------------------------------------------------------
package mux_channel_scanner_pkg;

   localparam int SEL_W  = 2;
   localparam int NUM_CH = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mux_channel_scanner_settle.sv
// -----------------------------------------------------------------------------
// mux_settle_counter
// Counts the cycles the mux select has been held stable.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   clear    : return the count to zero (takes priority over enable)
//   enable   : advance the count by one this cycle
//   terminal : count has reached SETTLE_CYCLES-1 (last settle cycle)
// -----------------------------------------------------------------------------
module mux_settle_counter #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   // With no settle phase the counter is never enabled; the terminal value
   // is pinned to zero so the subtraction cannot wrap.
   localparam logic [CNT_W-1:0] LP_LAST =
      (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples its inputs from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign terminal = (r_cnt == LP_LAST);

endmodule

// File: rtl/mux_channel_scanner.sv
// -----------------------------------------------------------------------------
// mux_channel_scanner
// Drives the select lines of an external 4-to-1 mux, waits SETTLE_CYCLES on
// each channel, samples the mux output and presents the assembled 4-bit word
// on a valid/ready handshake. Single-shot (start) or continuous scanning.
//   clk, rst   : system clock; synchronous active-high reset
//   start      : begin one scan (honoured only in IDLE)
//   continuous : start from IDLE and rescan after every handshake
//   mux_out    : mux output, sampled only in SAMPLE
//   s1, s0     : registered mux select
//   word       : bit i = mux_out captured with select = i
//   word_valid : word holds a complete scan
//   word_ready : consumer accepts word (ignored while word_valid = 0)
//   busy       : high in every state except IDLE
// -----------------------------------------------------------------------------
module mux_channel_scanner
   import mux_channel_scanner_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       continuous,
   input  logic       mux_out,
   output logic       s0,
   output logic       s1,
   output logic [3:0] word,
   output logic       word_valid,
   input  logic       word_ready,
   output logic       busy
);

   // State entered whenever a channel's select has just been applied.
   localparam state_t LP_SCAN_ST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
   localparam logic [SEL_W-1:0] LP_LAST_CH = SEL_W'(NUM_CH - 1);

   state_t              r_state;
   logic [SEL_W-1:0]    r_sel;
   logic [NUM_CH-2:0]   r_shadow;
   logic [NUM_CH-1:0]   r_word;
   logic                r_valid;
   logic                r_busy;

   state_t              w_state_nxt;
   logic [SEL_W-1:0]    w_sel_nxt;
   logic [NUM_CH-2:0]   w_shadow_nxt;
   logic [NUM_CH-1:0]   w_word_nxt;
   logic                w_valid_nxt;
   logic                w_settle_en;
   logic                w_settle_done;

   // Counter runs only in SETTLE and is held at zero everywhere else, so it
   // always starts from zero on entry to SETTLE.
   assign w_settle_en = (r_state == ST_SETTLE);

   mux_settle_counter #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_settle (
      .clk      (clk),
      .rst      (rst),
      .clear    (!w_settle_en),
      .enable   (w_settle_en),
      .terminal (w_settle_done)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_sel_nxt    = r_sel;
      w_shadow_nxt = r_shadow;
      w_word_nxt   = r_word;
      w_valid_nxt  = r_valid;

      unique case (r_state)
         ST_IDLE: begin
            if (start || continuous) begin
               w_sel_nxt   = '0;
               w_state_nxt = LP_SCAN_ST;
            end
         end
         ST_SETTLE: begin
            if (w_settle_done) begin
               w_state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (r_sel != LP_LAST_CH) begin
               w_shadow_nxt[r_sel] = mux_out;
               w_sel_nxt           = r_sel + 1'b1;
               w_state_nxt         = LP_SCAN_ST;
            end else begin
               // Last channel goes straight into the word; the shadow bits
               // hold channels 0..2.
               w_word_nxt  = {mux_out, r_shadow};
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (word_ready) begin
               w_valid_nxt = 1'b0;
               w_sel_nxt   = '0;
               w_state_nxt = continuous ? LP_SCAN_ST : ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_sel    <= '0;
         r_shadow <= '0;
         r_word   <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sel    <= w_sel_nxt;
         r_shadow <= w_shadow_nxt;
         r_word   <= w_word_nxt;
         r_valid  <= w_valid_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
      end
   end

   assign s0         = r_sel[0];
   assign s1         = r_sel[1];
   assign word       = r_word;
   assign word_valid = r_valid;
   assign busy       = r_busy;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// -----------------------------------------------------------------------------
// tb_mux_channel_scanner
// Directed bench for mux_channel_scanner. Two instances share clk/rst:
//   dut  : default SETTLE_CYCLES = 2
//   dut0 : SETTLE_CYCLES = 0
// Each drives a behavioural 4-to-1 mux built from a 4-bit data vector.
// Inputs change 1 time unit after the rising edge, outputs are read there.
// -----------------------------------------------------------------------------
module tb_mux_channel_scanner;

   logic       clk;
   logic       rst;

   logic       start, continuous, mux_out, s0, s1, word_valid, word_ready, busy;
   logic [3:0] word;
   logic [3:0] mux_d;
   logic       force_x;

   logic       start0, continuous0, mux_out0, s0_0, s1_0, word_valid0, word_ready0, busy0;
   logic [3:0] word0;
   logic [3:0] mux_d0;

   int n_cmp;
   int n_err;

   // Behavioural muxes; force_x models an undefined mux output.
   assign mux_out  = force_x ? 1'bx : mux_d[{s1, s0}];
   assign mux_out0 = mux_d0[{s1_0, s0_0}];

   mux_channel_scanner #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .continuous (continuous),
      .mux_out    (mux_out),
      .s0         (s0),
      .s1         (s1),
      .word       (word),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .busy       (busy)
   );

   mux_channel_scanner #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .start      (start0),
      .continuous (continuous0),
      .mux_out    (mux_out0),
      .s0         (s0_0),
      .s1         (s1_0),
      .word       (word0),
      .word_valid (word_valid0),
      .word_ready (word_ready0),
      .busy       (busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // rst together with start: rst wins; all outputs at reset values.
   task automatic test_reset();
      rst = 1'b1; start = 1'b1; start0 = 1'b1;
      tick(); tick();
      n_cmp++; if ({s1, s0} !== 2'b00) begin n_err++; $display("FAIL reset_sel got=%b exp=00", {s1, s0}); end
      n_cmp++; if (word !== 4'b0000) begin n_err++; $display("FAIL reset_word got=%b exp=0000", word); end
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if ({busy0, word_valid0, s1_0, s0_0} !== 4'b0000) begin n_err++; $display("FAIL reset_dut0 got=%b exp=0000", {busy0, word_valid0, s1_0, s0_0}); end
      rst = 1'b0; start = 1'b0; start0 = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
   endtask

   // Abort a scan while select = 10; no word may appear afterwards.
   task automatic test_reset_mid_scan();
      int bad;
      mux_d = 4'b1111;
      start = 1'b1; tick(); start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_start got=%b exp=1", busy); end
      repeat (6) tick();
      n_cmp++; if ({s1, s0} !== 2'b10) begin n_err++; $display("FAIL midrst_sel_before got=%b exp=10", {s1, s0}); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++; if ({s1, s0} !== 2'b00) begin n_err++; $display("FAIL midrst_sel got=%b exp=00", {s1, s0}); end
      n_cmp++; if (word !== 4'b0000) begin n_err++; $display("FAIL midrst_word got=%b exp=0000", word); end
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b exp=0", word_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (word_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL midrst_no_pulse got=%0d bad cycles exp=0", bad); end
   endtask

   // One scan of 1010 with word_ready held high throughout (ignored until valid).
   task automatic test_single_scan();
      logic [1:0] exp_sel;
      mux_d = 4'b1010; word_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_sel = (k < 12) ? 2'(k / 3) : 2'd3;
         n_cmp++; if ({s1, s0} !== exp_sel) begin n_err++; $display("FAIL single_sel edge=%0d got=%b exp=%b", k, {s1, s0}, exp_sel); end
         n_cmp++; if (word_valid !== (k == 12)) begin n_err++; $display("FAIL single_valid edge=%0d got=%b exp=%b", k, word_valid, (k == 12)); end
      end
      n_cmp++; if (word !== 4'b1010) begin n_err++; $display("FAIL single_word got=%b exp=1010", word); end
      tick();
      word_ready = 1'b0;
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop got=%b exp=0", word_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_drop got=%b exp=0", busy); end
      n_cmp++; if ({s1, s0} !== 2'b00) begin n_err++; $display("FAIL single_sel_idle got=%b exp=00", {s1, s0}); end
   endtask

   // Hold word for 20 cycles with ready low and start pulsing; then release.
   task automatic test_backpressure();
      int bad;
      mux_d = 4'b0101; word_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (12) tick();
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         start = k[0];
         mux_d = ~mux_d;
         tick();
         if (word !== 4'b0101 || word_valid !== 1'b1 || {s1, s0} !== 2'b11 || busy !== 1'b1) bad++;
      end
      start = 1'b0; mux_d = 4'b0101;
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold got=%0d bad cycles exp=0", bad); end
      word_ready = 1'b1; tick(); word_ready = 1'b0;
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", word_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_restart got=%b exp=0", busy); end
   endtask

   // Continuous: words 0110, 1001, 1001 every 13 cycles; continuous dropped
   // during the third scan, which completes and then returns to IDLE.
   task automatic test_continuous();
      logic       exp_v;
      logic [3:0] exp_w;
      mux_d = 4'b0110; word_ready = 1'b1; continuous = 1'b1;
      tick();
      for (int k = 1; k <= 39; k++) begin
         tick();
         if (k == 12) mux_d = 4'b1001;
         if (k == 27) continuous = 1'b0;
         exp_v = (k == 12) || (k == 25) || (k == 38);
         exp_w = (k < 25) ? 4'b0110 : 4'b1001;
         n_cmp++; if (word_valid !== exp_v) begin n_err++; $display("FAIL cont_valid edge=%0d got=%b exp=%b", k, word_valid, exp_v); end
         if (exp_v) begin
            n_cmp++; if (word !== exp_w) begin n_err++; $display("FAIL cont_word edge=%0d got=%b exp=%b", k, word, exp_w); end
         end
      end
      word_ready = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_idle_busy got=%b exp=0", busy); end
   endtask

   // SETTLE_CYCLES = 0: select advances every edge, valid 4 edges after start.
   task automatic test_settle_zero();
      logic [1:0] exp_sel;
      mux_d0 = 4'b1111; word_ready0 = 1'b0;
      start0 = 1'b1; tick(); start0 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_sel = (k < 4) ? 2'(k) : 2'd3;
         n_cmp++; if ({s1_0, s0_0} !== exp_sel) begin n_err++; $display("FAIL s0_sel edge=%0d got=%b exp=%b", k, {s1_0, s0_0}, exp_sel); end
         n_cmp++; if (word_valid0 !== (k == 4)) begin n_err++; $display("FAIL s0_valid edge=%0d got=%b exp=%b", k, word_valid0, (k == 4)); end
      end
      n_cmp++; if (word0 !== 4'b1111) begin n_err++; $display("FAIL s0_word got=%b exp=1111", word0); end
      word_ready0 = 1'b1; tick(); word_ready0 = 1'b0;
      n_cmp++; if ({busy0, word_valid0} !== 2'b00) begin n_err++; $display("FAIL s0_release got=%b exp=00", {busy0, word_valid0}); end
   endtask

   // mux_out is X on every non-sample cycle; the word must carry only the
   // values present on the four sampling edges (3, 6, 9, 12).
   task automatic test_x_tolerance();
      mux_d = 4'b1100; word_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         force_x = ((k % 3) != 0);
         tick();
      end
      force_x = 1'b1;
      tick();
      n_cmp++; if (word !== 4'b1100) begin n_err++; $display("FAIL xtol_word got=%b exp=1100", word); end
      n_cmp++; if ((^word) === 1'bx) begin n_err++; $display("FAIL xtol_no_x got=%b exp=known", word); end
      force_x = 1'b0;
      word_ready = 1'b1; tick(); word_ready = 1'b0;
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL xtol_release got=%b exp=0", word_valid); end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b1;
      start = 1'b0; continuous = 1'b0; word_ready = 1'b0; mux_d = 4'b0000; force_x = 1'b0;
      start0 = 1'b0; continuous0 = 1'b0; word_ready0 = 1'b0; mux_d0 = 4'b0000;
      test_reset();
      test_reset_mid_scan();
      test_single_scan();
      test_backpressure();
      test_continuous();
      test_settle_zero();
      test_x_tolerance();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux_channel_scanner.md
Name: mux_channel_scanner

Overview:
- Sequencer that sits directly upstream of the 4-to-1 mux and drives its select lines s1/s0.
- Also sits downstream of it: consumes the mux output.
- Steps through channels 0..3, waits a settle interval on each, samples the mux output, and assembles a 4-bit word {d3,d2,d1,d0}.
- Presents the word on a valid/ready handshake. Supports single-shot and continuous scanning.

Parameters:
- SETTLE_CYCLES, 2: clock cycles select is held stable before sampling; 0 is legal (no settle phase).
- CNT_W, 4: settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin one scan; sampled only in IDLE.
- continuous  input  1  when 1, rescan automatically after each handshake; also starts a scan from IDLE.
- mux_out  input  1  output of the 4-to-1 mux.
- s0  output  1  mux select LSB.
- s1  output  1  mux select MSB.
- word  output  4  assembled sample, bit i = mux_out captured with select = i.
- word_valid  output  1  word holds a complete scan.
- word_ready  input  1  consumer accepts word.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at rising edge, any state):
  - state=IDLE, {s1,s0}=00, word=0000, word_valid=0, busy=0.
  - Shadow bits cleared.
  - An in-progress scan is aborted and partial bits are discarded.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - If start=1 or continuous=1 at an edge: sel=00, settle_cnt=0, busy=1.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
- SETTLE:
  - settle_cnt increments each cycle; select held constant.
  - When settle_cnt = SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle per channel):
  - shadow[sel] <= mux_out.
  - If sel != 3: sel increments, settle_cnt=0, go to SETTLE (or stay in SAMPLE if SETTLE_CYCLES=0).
  - If sel = 3: word <= {mux_out, shadow[2:0]}, word_valid <= 1, go to DONE.
- DONE:
  - word, word_valid and select hold until word_ready=1 at an edge.
  - On that edge: word_valid <= 0.
  - If continuous=1: sel=00 and go to SETTLE/SAMPLE. Otherwise go to IDLE, busy=0, select returns to 00.
- Latency: word_valid rises exactly 4*(SETTLE_CYCLES+1) edges after the edge that accepted start (12 for default).
- Handshake rules:
  - word_ready while word_valid=0 is ignored.
  - start while busy=1 is ignored (no restart, no queueing).
  - word is stable for the entire time word_valid=1.
- mux_out is sampled only in SAMPLE. X on mux_out in any other cycle has no effect. An X captured in SAMPLE propagates unchanged into word.
- Simultaneous rst and start: rst wins.
- continuous dropped mid-scan: the current scan completes, then the block returns to IDLE after the handshake.
- Select changes only on a SAMPLE->next transition, never in SETTLE or DONE.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - SEL_W=2.
  - NUM_CH=4.
- One sub-module: mux_settle_counter.
  - Inputs: clk, rst, clear, enable.
  - Output: terminal flag.
  - Parameterised by SETTLE_CYCLES/CNT_W.
- Top module instantiates the settle counter and the FSM. The 4-to-1 mux itself stays external; the bench connects a behavioural copy.

Test Plan:
- Reset mid-scan: start, assert rst while sel=10 -> next edge s1s0=00, word=0000, word_valid=0, busy=0; no valid pulse follows.
- Single scan, default params: mux data d3..d0=1010, pulse start -> s1s0 steps 00,01,10,11 every 3 cycles; word_valid rises 12 edges after start with word=1010; word_ready=1 -> valid drops next edge, busy=0, s1s0=00.
- Backpressure: complete scan with word_ready=0 for 20 cycles -> word and word_valid constant, select stays 11; start pulses in that window ignored; ready=1 releases.
- Continuous mode: continuous=1, ready tied 1, data 0110 then 1001 -> back-to-back words 0110, 1001, each valid for one cycle; 13 cycles apart.
- SETTLE_CYCLES=0 build: data 1111 -> select changes every edge, word_valid 4 edges after start, word=1111.
- X tolerance: drive unselected mux inputs to X as in the mux bench -> word contains no X; selected-channel values only.
